mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Memory-side stage sitting directly downstream of the multi-cycle control FSM.
- Consumes MemR, MemW, IRWrite and IoD, selects the address as PC or ALUOut, and runs a req/ack handshake to a variable-latency 16-bit word memory.
- Latches fetched words into the instruction register (IR) and loaded words into the memory data register (MDR).
- Raises Stall so the control FSM holds its state until the access completes.

Parameters:
- DATA_W, 16, data and instruction width
- ADDR_W, 16, word address width
- TIMEOUT, 15, maximum cycles mem_req may wait for mem_ack before aborting; must be >= 1

Ports:
- CLK  in  1  system clock; all state updates on its rising edge
- Reset_n  in  1  synchronous, active-low reset
- IRWrite  in  1  instruction fetch request from the control FSM
- MemR  in  1  data read request
- MemW  in  1  data write request
- IoD  in  1  address select: 0 = PC, 1 = ALUOut
- PC  in  ADDR_W  current program counter
- ALUOut  in  ADDR_W  data address
- WriteData  in  DATA_W  store data (rt)
- Stall  out  1  control FSM must not advance while high
- IR  out  DATA_W  instruction register
- MDR  out  DATA_W  memory data register
- BusErr  out  1  sticky timeout or illegal-command flag
- mem_req  out  1  memory request
- mem_we  out  1  write enable, valid while mem_req is high
- mem_addr  out  ADDR_W  request address, stable while mem_req is high
- mem_wdata  out  DATA_W  write data, stable while mem_req is high
- mem_rdata  in  DATA_W  read data, valid in the cycle mem_ack is high
- mem_ack  in  1  memory completion, one cycle

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-low (Reset_n).
- Reset (Reset_n low at an edge): state=IDLE, IR=0, MDR=0, BusErr=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout counter=0.
- Reset mid-access: the same values load at that edge; a pending mem_ack is ignored.
- cmd = IRWrite | MemR | MemW.
- Kind decode, priority MemW > IRWrite > MemR:
  - write if MemW
  - fetch if IRWrite and not MemW
  - read otherwise
- Illegal command: MemW together with MemR or IRWrite. The write is still performed and BusErr is set.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If cmd is high: latch mem_addr = (IoD ? ALUOut : PC), mem_wdata = WriteData, mem_we = kind==write, and the kind; clear the counter; go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req=1.
  - If mem_ack: a fetch loads IR<=mem_rdata; a read loads MDR<=mem_rdata; a write loads neither. Go to DONE.
  - Else if counter==TIMEOUT-1: BusErr<=1, IR and MDR unchanged, go to DONE.
  - Else counter++.
- DONE:
  - mem_req=0; cmd is ignored in this cycle, because the control FSM is still presenting the same state.
  - Go to IDLE.
- Stall (combinational) = (IDLE & cmd) | REQ. It is low in DONE, so the control FSM advances at the edge that ends DONE.
- Latency, zero-wait memory (ack in the first REQ cycle):
  - cycle0 IDLE with cmd, Stall=1
  - cycle1 REQ with ack, Stall=1
  - cycle2 DONE, IR/MDR valid, Stall=0
- Each wait cycle of the memory adds one cycle.
- mem_req drops in the cycle after ack and stays low for at least one cycle (DONE) before the next request.
- mem_ack while not in REQ is ignored.
- IR and MDR hold their values until the next completed fetch or read respectively.
- BusErr clears only on reset.
- No address arithmetic; addresses pass through unmodified.

Decomposition:
- Shared package mem_access_pkg holds:
  - state encodings IDLE=2'd0, REQ=2'd1, DONE=2'd2
  - kind encodings FETCH=2'd0, READ=2'd1, WRITE=2'd2
  - DATA_W and ADDR_W defaults
- The timeout counter is a natural sub-module: mem_timeout_counter (clear, enable, terminal-count output).
- Everything else stays in one module.

Test Plan:
- Fetch, zero wait: IRWrite=1, IoD=0, PC=16'h0010; memory acks at first req with 16'h1234 -> mem_addr=16'h0010, mem_we=0, Stall high for 2 cycles, IR=16'h1234 in DONE, MDR stays 0.
- Read, 3 wait states: MemR=1, IoD=1, ALUOut=16'h0200; ack after 3 cycles with 16'hBEEF -> mem_req high for 4 cycles, Stall high for 5 cycles, MDR=16'hBEEF, IR unchanged.
- Write: MemW=1, IoD=1, ALUOut=16'h0300, WriteData=16'h00A5 -> mem_we=1, mem_addr=16'h0300, mem_wdata=16'h00A5 for the whole req, IR and MDR unchanged, BusErr=0.
- Timeout: MemR=1, no ack -> after 15 REQ cycles go to DONE, BusErr=1, MDR unchanged; a following fetch still completes normally with BusErr still 1.
- Reset mid-access: drive Reset_n low during REQ after a fetch has loaded IR=16'h1234 -> next cycle mem_req=0, Stall=0, IR=0, state IDLE; an ack arriving one cycle later has no effect.
- Illegal and back-to-back: MemW=1 and MemR=1 -> write performed, BusErr=1. Then a fetch presented in DONE is ignored and starts only from IDLE, so mem_req shows one low cycle between accesses.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings and width defaults for the memory access stage.
package mem_access_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } kind_e;

    // Write wins over fetch, fetch wins over read.
    function automatic kind_e decode_kind(input logic irwrite, input logic memw);
        if (memw) begin
            return WRITE;
        end else if (irwrite) begin
            return FETCH;
        end
        return READ;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter for an outstanding memory request; tc marks the last allowed cycle.
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic CLK,
    input  logic Reset_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (!Reset_n || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side stage: turns control FSM strobes into a req/ack access and latches IR/MDR.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              IRWrite,
    input  logic              MemR,
    input  logic              MemW,
    input  logic              IoD,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] WriteData,
    output logic              Stall,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] MDR,
    output logic              BusErr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_e state_q, state_d;
    kind_e  kind_q;
    logic   cmd, illegal, cnt_clr, cnt_en, tc;

    assign cmd     = IRWrite | MemR | MemW;
    assign illegal = MemW & (MemR | IRWrite);
    assign mem_req = (state_q == REQ);

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .clear   (cnt_clr),
        .enable  (cnt_en),
        .tc      (tc)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        Stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd) begin
                    Stall   = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                Stall = 1'b1;
                if (mem_ack || tc) begin
                    state_d = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            // The control FSM still shows the old command here, so it is ignored.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            kind_q    <= FETCH;
            IR        <= '0;
            MDR       <= '0;
            BusErr    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cmd) begin
                mem_addr  <= IoD ? ALUOut : PC;
                mem_wdata <= WriteData;
                mem_we    <= MemW;
                kind_q    <= decode_kind(IRWrite, MemW);
                if (illegal) begin
                    BusErr <= 1'b1;
                end
            end
            if (state_q == REQ) begin
                if (mem_ack) begin
                    if (kind_q == FETCH) begin
                        IR <= mem_rdata;
                    end else if (kind_q == READ) begin
                        MDR <= mem_rdata;
                    end
                end else if (tc) begin
                    BusErr <= 1'b1;
                end
            end
        end
    end

endmodule
